// File: rtl/pipe_perf_monitor_pkg.sv
// pipe_perf_pkg: shared types and constants for the pipeline performance monitor.
//   state_e        run-control FSM encoding
//   SEL_*          read-port select codes
//   CNT_W_DEF/PC_W_DEF  default counter / PC widths
package pipe_perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic [2:0] SEL_CYCLE      = 3'd0;
    localparam logic [2:0] SEL_STALL      = 3'd1;
    localparam logic [2:0] SEL_FLUSH      = 3'd2;
    localparam logic [2:0] SEL_RETIRE     = 3'd3;
    localparam logic [2:0] SEL_LAST_PC    = 3'd4;
    localparam logic [2:0] SEL_CPI        = 3'd5;
    localparam logic [2:0] SEL_SNAP_STALL = 3'd6;
    localparam logic [2:0] SEL_SNAP_FLUSH = 3'd7;

    localparam int CNT_W_DEF = 32;
    localparam int PC_W_DEF  = 32;

endpackage

// File: rtl/pipe_perf_monitor_if.sv
// pipe_perf_if: pipeline event strobes plus the counter read port.
//   master: pipeline side (drives strobes, rd_sel; samples rd_data)
//   slave : monitor side
// With PERF_SNAPSHOT_EN defined the bundle also carries the snap strobe.
interface pipe_perf_if
    import pipe_perf_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PC_W  = PC_W_DEF
);
    logic             pc_hold;
    logic             ifid_hold;
    logic             flush;
    logic             retire;
    logic [PC_W-1:0]  retire_pc;
    logic [2:0]       rd_sel;
    logic [CNT_W-1:0] rd_data;
`ifdef PERF_SNAPSHOT_EN
    logic             snap;
`endif

    modport master (
        output pc_hold, ifid_hold, flush, retire, retire_pc, rd_sel,
`ifdef PERF_SNAPSHOT_EN
        output snap,
`endif
        input  rd_data
    );

    modport slave (
        input  pc_hold, ifid_hold, flush, retire, retire_pc, rd_sel,
`ifdef PERF_SNAPSHOT_EN
        input  snap,
`endif
        output rd_data
    );
endinterface

// File: rtl/pipe_perf_monitor_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
//   clk_i, rst_i (sync, active-low), inc_i (count enable), clr_i (zero, wins over inc_i)
//   cnt_o: current count
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_perf_monitor.sv
// pipe_perf_monitor: counts cycles, stalls, flushes and retirements while the
// CPU runs, records the last retired PC, and halts after CYCLE_LIMIT run cycles
// (CYCLE_LIMIT = 0 disables auto-halt).
//   clk_i, rst_i (sync, active-low), start_i (level), clear_i (pulse)
//   bus       : pipe_perf_if.slave (event strobes, rd_sel -> registered rd_data)
//   running_o : state is RUN, halt_o : state is HALTED
// Optional macro PERF_SNAPSHOT_EN: bus.snap copies the counters into shadow
// registers; selects 6/7 then read shadow stall/flush instead of 0.
//
// state   | meaning
// IDLE    | waiting for start_i, counters hold
// RUN     | counting events
// HALTED  | cycle budget spent, waits for clear_i
module pipe_perf_monitor
    import pipe_perf_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int          PC_W        = PC_W_DEF,
    parameter int unsigned CYCLE_LIMIT = 30
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        clear_i,
    pipe_perf_if.slave  bus,
    output logic        running_o,
    output logic        halt_o
);
    // Compare in 64 bits so a limit larger than the counter range never halts early.
    localparam longint unsigned HALT_AT = 64'(CYCLE_LIMIT) - 64'd1;

    state_e           state_q, state_d;
    logic             run_en;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt, retire_cnt;
    logic [PC_W-1:0]  last_pc_q;
    logic [CNT_W-1:0] last_pc_rd, cpi_val, rd_mux, rd_data_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN: begin
                if (CYCLE_LIMIT != 0 && 64'(cycle_cnt) == HALT_AT) state_d = ST_HALTED;
                else if (!start_i)                                 state_d = ST_IDLE;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
        if (clear_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    assign run_en    = (state_q == ST_RUN) && !clear_i;
    assign running_o = (state_q == ST_RUN);
    assign halt_o    = (state_q == ST_HALTED);

    sat_counter #(.W(CNT_W)) u_cycle (.clk_i(clk_i), .rst_i(rst_i), .inc_i(run_en),
        .clr_i(clear_i), .cnt_o(cycle_cnt));
    sat_counter #(.W(CNT_W)) u_stall (.clk_i(clk_i), .rst_i(rst_i),
        .inc_i(run_en && bus.pc_hold && bus.ifid_hold), .clr_i(clear_i), .cnt_o(stall_cnt));
    sat_counter #(.W(CNT_W)) u_flush (.clk_i(clk_i), .rst_i(rst_i),
        .inc_i(run_en && bus.flush), .clr_i(clear_i), .cnt_o(flush_cnt));
    sat_counter #(.W(CNT_W)) u_retire (.clk_i(clk_i), .rst_i(rst_i),
        .inc_i(run_en && bus.retire), .clr_i(clear_i), .cnt_o(retire_cnt));

    always_ff @(posedge clk_i) begin
        if (!rst_i)                    last_pc_q <= '0;
        else if (clear_i)              last_pc_q <= '0;
        else if (run_en && bus.retire) last_pc_q <= bus.retire_pc;
    end

    generate
        if (PC_W >= CNT_W) begin : g_pc_trunc
            assign last_pc_rd = last_pc_q[CNT_W-1:0];
        end else begin : g_pc_ext
            assign last_pc_rd = {{(CNT_W-PC_W){1'b0}}, last_pc_q};
        end
    endgenerate

    assign cpi_val = (cycle_cnt >= retire_cnt) ? (cycle_cnt - retire_cnt) : '0;

`ifdef PERF_SNAPSHOT_EN
    // Shadows survive clear_i so a snapshot can be compared against a fresh run.
    logic [CNT_W-1:0] shadow_cycle_q, shadow_stall_q, shadow_flush_q, shadow_retire_q;
    logic [PC_W-1:0]  shadow_pc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            shadow_cycle_q  <= '0;
            shadow_stall_q  <= '0;
            shadow_flush_q  <= '0;
            shadow_retire_q <= '0;
            shadow_pc_q     <= '0;
        end else if (bus.snap) begin
            shadow_cycle_q  <= cycle_cnt;
            shadow_stall_q  <= stall_cnt;
            shadow_flush_q  <= flush_cnt;
            shadow_retire_q <= retire_cnt;
            shadow_pc_q     <= last_pc_q;
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (bus.rd_sel)
            SEL_CYCLE:      rd_mux = cycle_cnt;
            SEL_STALL:      rd_mux = stall_cnt;
            SEL_FLUSH:      rd_mux = flush_cnt;
            SEL_RETIRE:     rd_mux = retire_cnt;
            SEL_LAST_PC:    rd_mux = last_pc_rd;
            SEL_CPI:        rd_mux = cpi_val;
`ifdef PERF_SNAPSHOT_EN
            SEL_SNAP_STALL: rd_mux = shadow_stall_q;
            SEL_SNAP_FLUSH: rd_mux = shadow_flush_q;
`endif
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) rd_data_q <= '0;
        else        rd_data_q <= rd_mux;
    end

    assign bus.rd_data = rd_data_q;
endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor: instance A (32-bit, limit 30) covers
// run-control, event counting, read port, clear and reset; instance B
// (4-bit, no auto-halt) covers saturation.
module tb_pipe_perf_monitor;
    logic clk = 1'b0;
    logic rst_b;
    logic start_a, clear_a, start_b, clear_b;
    logic run_a, halt_a, run_b, halt_b;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipe_perf_if #(.CNT_W(32), .PC_W(32)) a_if ();
    pipe_perf_if #(.CNT_W(4),  .PC_W(8))  b_if ();

    pipe_perf_monitor #(.CNT_W(32), .PC_W(32), .CYCLE_LIMIT(30)) u_a (
        .clk_i(clk), .rst_i(rst_b), .start_i(start_a), .clear_i(clear_a),
        .bus(a_if.slave), .running_o(run_a), .halt_o(halt_a));

    pipe_perf_monitor #(.CNT_W(4), .PC_W(8), .CYCLE_LIMIT(0)) u_b (
        .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .clear_i(clear_b),
        .bus(b_if.slave), .running_o(run_b), .halt_o(halt_b));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_a(input logic [2:0] sel);
        a_if.rd_sel = sel;
        step();
    endtask

    task automatic rd_b(input logic [2:0] sel);
        b_if.rd_sel = sel;
        step();
    endtask

    task automatic events_a(input logic ph, input logic ih, input logic fl,
                            input logic rt, input logic [31:0] pc);
        a_if.pc_hold   = ph;
        a_if.ifid_hold = ih;
        a_if.flush     = fl;
        a_if.retire    = rt;
        a_if.retire_pc = pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_b = 1'b0;
        start_a = 1'b0; clear_a = 1'b0; start_b = 1'b0; clear_b = 1'b0;
        events_a(0, 0, 0, 0, 32'h0);
        a_if.rd_sel = 3'd0;
        b_if.pc_hold = 1'b0; b_if.ifid_hold = 1'b0; b_if.flush = 1'b0;
        b_if.retire = 1'b0; b_if.retire_pc = 8'h0; b_if.rd_sel = 3'd0;
`ifdef PERF_SNAPSHOT_EN
        a_if.snap = 1'b0;
        b_if.snap = 1'b0;
`endif
        step(); step();
        check_eq("rst_running", run_a, 0);
        check_eq("rst_halt", halt_a, 0);
        check_eq("rst_rd_data", a_if.rd_data, 0);

        // Budget of 30 run cycles, no events.
        rst_b = 1'b1;
        start_a = 1'b1;
        step();
        check_eq("run_after_start", run_a, 1);
        check_eq("no_halt_at_start", halt_a, 0);
        repeat (29) step();
        check_eq("run_at_29", run_a, 1);
        check_eq("no_halt_at_29", halt_a, 0);
        step();
        check_eq("halt_at_30", halt_a, 1);
        check_eq("not_running_halted", run_a, 0);
        rd_a(3'd0); check_eq("cycle_30", a_if.rd_data, 30);
        rd_a(3'd1); check_eq("stall_0", a_if.rd_data, 0);
        rd_a(3'd2); check_eq("flush_0", a_if.rd_data, 0);
        rd_a(3'd3); check_eq("retire_0", a_if.rd_data, 0);
        rd_a(3'd5); check_eq("cpi_30", a_if.rd_data, 30);
        rd_a(3'd6); check_eq("sel6_0", a_if.rd_data, 0);
        repeat (3) step();
        rd_a(3'd0); check_eq("cycle_held_halted", a_if.rd_data, 30);
        check_eq("halt_sticky", halt_a, 1);

        // clear_i beats start_i; RUN resumes the next cycle.
        clear_a = 1'b1;
        step();
        check_eq("clear_halt", halt_a, 0);
        check_eq("clear_running", run_a, 0);
        clear_a = 1'b0;
        step();
        check_eq("rerun_after_clear", run_a, 1);
        check_eq("cycle_cleared", a_if.rd_data, 0);

        // 3 full stalls, 2 pc-only holds, 2 flushes, 3 retires: 10 run cycles.
        events_a(1, 1, 0, 0, 32'h0); repeat (3) step();
        events_a(1, 0, 0, 0, 32'h0); repeat (2) step();
        events_a(0, 0, 1, 0, 32'h0); repeat (2) step();
        events_a(0, 0, 0, 1, 32'h00); step();
        events_a(0, 0, 0, 1, 32'h04); step();
        events_a(0, 0, 0, 1, 32'h0C); step();
        events_a(0, 0, 0, 0, 32'h0);
        rd_a(3'd1); check_eq("stall_3", a_if.rd_data, 3);
        rd_a(3'd2); check_eq("flush_2", a_if.rd_data, 2);
        rd_a(3'd3); check_eq("retire_3", a_if.rd_data, 3);
        rd_a(3'd4); check_eq("last_pc_0c", a_if.rd_data, 32'h0C);
        rd_a(3'd5); check_eq("cpi_14_minus_3", a_if.rd_data, 11);
        rd_a(3'd0); check_eq("cycle_pre_15", a_if.rd_data, 15);

        // Dropping start_i returns to IDLE; the drop cycle is still counted.
        start_a = 1'b0;
        step();
        check_eq("idle_on_start_drop", run_a, 0);
        check_eq("read_pre_inc_16", a_if.rd_data, 16);
        step();
        check_eq("cycle_17", a_if.rd_data, 17);
        events_a(1, 1, 1, 1, 32'h40);
        rd_a(3'd2); check_eq("flush_held_idle", a_if.rd_data, 2);
        rd_a(3'd4); check_eq("pc_held_idle", a_if.rd_data, 32'h0C);

        // Reset in RUN with all events active.
        start_a = 1'b1;
        rd_a(3'd0);
        step();
        rst_b = 1'b0;
        step();
        check_eq("rst_mid_running", run_a, 0);
        check_eq("rst_mid_halt", halt_a, 0);
        check_eq("rst_mid_rd_data", a_if.rd_data, 0);
        rst_b = 1'b1;
        start_a = 1'b0;
        rd_a(3'd1); check_eq("rst_mid_stall", a_if.rd_data, 0);
        rd_a(3'd3); check_eq("rst_mid_retire", a_if.rd_data, 0);
        rd_a(3'd4); check_eq("rst_mid_pc", a_if.rd_data, 0);
        events_a(0, 0, 0, 0, 32'h0);

        // 4-bit counters, no auto-halt: saturate at 15.
        start_b = 1'b1;
        b_if.pc_hold = 1'b1; b_if.ifid_hold = 1'b1;
        step();
        repeat (20) step();
        check_eq("b_running", run_b, 1);
        check_eq("b_no_halt", halt_b, 0);
        rd_b(3'd0); check_eq("b_cycle_sat", b_if.rd_data, 15);
        rd_b(3'd1); check_eq("b_stall_sat", b_if.rd_data, 15);
        rd_b(3'd3); check_eq("b_retire_0", b_if.rd_data, 0);
        rd_b(3'd5); check_eq("b_cpi_sat", b_if.rd_data, 15);
        check_eq("b_still_running", run_b, 1);
        start_b = 1'b0;
        b_if.pc_hold = 1'b0; b_if.ifid_hold = 1'b0;

`ifdef PERF_SNAPSHOT_EN
        start_a = 1'b1;
        step();
        events_a(1, 1, 0, 0, 32'h0); repeat (2) step();
        events_a(0, 0, 0, 0, 32'h0);
        a_if.snap = 1'b1;
        step();
        a_if.snap = 1'b0;
        events_a(1, 1, 0, 0, 32'h0); repeat (3) step();
        events_a(0, 0, 0, 0, 32'h0);
        rd_a(3'd6); check_eq("snap_stall_2", a_if.rd_data, 2);
        rd_a(3'd1); check_eq("live_stall_5", a_if.rd_data, 5);
        rd_a(3'd7); check_eq("snap_flush_0", a_if.rd_data, 0);
        start_a = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
